// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the two-requester ALU sequencer: opcode encodings, FSM
// state encodings and the source identifiers reported on out_src.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AVG  = 3'b000,  // (x+y)/2
        OP_DBL  = 3'b001,  // 2*(x+y)
        OP_HX_Y = 3'b010,  // x/2 + y
        OP_X_HY = 3'b011,  // x - y/2
        OP_NOR  = 3'b100,  // (x==0)|(y==0)
        OP_NX   = 3'b101,  // (x==0)
        OP_NAND = 3'b110,  // (x==0)&(y==0)
        OP_XOR  = 3'b111   // x^y
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/alu_arbiter_seq_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_seq_if
// Bundles both requester command channels and the result channel.
//   a_valid/a_ready/a_x/a_y/a_op : requester A command handshake
//   b_valid/b_ready/b_x/b_y/b_op : requester B command handshake
//   out_valid/out_ready          : result handshake
//   out_result (N+2), out_src    : registered result and its source
//   op_count (8)                 : delivered-result counter, wraps at 256
// Modports: master = requesters + consumer, slave = the sequencer.
// ---------------------------------------------------------------------------
interface alu_arbiter_seq_if #(parameter int N = 4);

    logic           a_valid;
    logic           a_ready;
    logic [N-1:0]   a_x;
    logic [N-1:0]   a_y;
    logic [2:0]     a_op;

    logic           b_valid;
    logic           b_ready;
    logic [N-1:0]   b_x;
    logic [N-1:0]   b_y;
    logic [2:0]     b_op;

    logic           out_valid;
    logic           out_ready;
    logic [N+1:0]   out_result;
    logic           out_src;
    logic [7:0]     op_count;

    modport master (
        output a_valid, a_x, a_y, a_op,
        output b_valid, b_x, b_y, b_op,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_result, out_src, op_count
    );

    modport slave (
        input  a_valid, a_x, a_y, a_op,
        input  b_valid, b_x, b_y, b_op,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_result, out_src, op_count
    );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational signed ALU.
//   x, y   (N)   : signed operands
//   op     (3)   : opcode (alu_op_e)
//   result (N+2) : sign-extended evaluation truncated to N+2 bits
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  alu_op_e      op,
    output logic [N+1:0] result
);

    // One guard bit beyond the result width keeps 2*(x+y) from overflowing
    // before truncation.
    localparam int W = N + 3;

    logic signed [W-1:0] w_xs;
    logic signed [W-1:0] w_ys;
    logic signed [W-1:0] w_sum;
    logic signed [W-1:0] w_r;

    // Halving that truncates toward zero: negative values get +1 before the
    // arithmetic shift so -3/2 yields -1, not -2.
    function automatic logic signed [W-1:0] half(input logic signed [W-1:0] v);
        logic signed [W-1:0] c;
        logic signed [W-1:0] t;
        c    = '0;
        c[0] = v[W-1];
        t    = v + c;
        return t >>> 1;
    endfunction

    always_comb begin
        w_xs  = {{(W-N){x[N-1]}}, x};
        w_ys  = {{(W-N){y[N-1]}}, y};
        w_sum = w_xs + w_ys;
        w_r   = '0;
        unique case (op)
            OP_AVG:  w_r = half(w_sum);
            OP_DBL:  w_r = w_sum <<< 1;
            OP_HX_Y: w_r = half(w_xs) + w_ys;
            OP_X_HY: w_r = w_xs - half(w_ys);
            OP_NOR:  w_r[0] = (x == '0) || (y == '0);
            OP_NX:   w_r[0] = (x == '0);
            OP_NAND: w_r[0] = (x == '0) && (y == '0);
            OP_XOR:  w_r = w_xs ^ w_ys;
            default: w_r = '0;
        endcase
        result = w_r[N+1:0];
    end

endmodule

// File: rtl/alu_arbiter_seq.sv
// ---------------------------------------------------------------------------
// alu_arbiter_seq
// Round-robin sequencer sharing one alu_core between requesters A and B.
// IDLE grants one requester (one-cycle ready pulse, operands latched),
// EXEC registers the ALU result, HOLD presents it until out_ready.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : alu_arbiter_seq_if.slave (command and result channels)
// ---------------------------------------------------------------------------
module alu_arbiter_seq
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_arbiter_seq_if.slave    bus
);

    state_e        r_state;
    state_e        w_next;
    logic          r_last;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_y;
    alu_op_e       r_op;
    logic [N+1:0]  r_result;
    logic          r_valid;
    logic          r_src;
    logic [7:0]    r_count;
    logic [N+1:0]  w_alu;
    logic          w_grant_a;
    logic          w_grant_b;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.a_valid || bus.b_valid) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_HOLD;
            ST_HOLD: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant decode. On a tie the requester that did not win last time wins.
    // Gated by reset so ready stays low while reset is held.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == ST_IDLE && !reset) begin
            w_grant_a = bus.a_valid && (!bus.b_valid || r_last == SRC_B);
            w_grant_b = bus.b_valid && !w_grant_a;
        end
    end

    // Operand latch, arbitration pointer, result register and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_op     <= OP_AVG;
            r_src    <= SRC_A;
            r_last   <= SRC_B;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_grant_a || w_grant_b) begin
                r_x    <= w_grant_a ? bus.a_x : bus.b_x;
                r_y    <= w_grant_a ? bus.a_y : bus.b_y;
                r_op   <= alu_op_e'(w_grant_a ? bus.a_op : bus.b_op);
                r_src  <= w_grant_b ? SRC_B : SRC_A;
                r_last <= w_grant_b ? SRC_B : SRC_A;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu;
                r_valid  <= 1'b1;
            end
            if (r_state == ST_HOLD && bus.out_ready) begin
                r_valid <= 1'b0;
                r_count <= r_count + 8'd1;
            end
        end
    end

    alu_core #(.N(N)) u_alu (
        .x      (r_x),
        .y      (r_y),
        .op     (r_op),
        .result (w_alu)
    );

    assign bus.a_ready    = w_grant_a;
    assign bus.b_ready    = w_grant_b;
    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_src    = r_src;
    assign bus.op_count   = r_count;

endmodule

// File: doc/alu_arbiter_seq.md
# alu_arbiter_seq

Two-requester sequencer that shares one combinational signed ALU datapath between two command sources. It arbitrates round-robin, latches the winning operands and opcode, evaluates them in one cycle, and holds a registered result under a valid/ready handshake until the consumer takes it. It sits between the command sources and the result consumer, so the ALU is never driven by two sources at once.

## Interface
Parameters:
- N, 4, operand width; result width is N+2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a command.
- a_ready  out  1  A's command is accepted this cycle.
- a_x, a_y  in  N each  A's signed operands.
- a_op  in  3  A's opcode.
- b_valid, b_ready, b_x, b_y, b_op: same as the A ports, for requester B.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result.
- out_result  out  N+2  registered ALU result.
- out_src  out  1  source of the result: 0 = A, 1 = B.
- op_count  out  8  number of results delivered, wraps modulo 256.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - With no request pending, stay in IDLE.
  - With one or both valids high, grant one requester. Pulse its ready for exactly this cycle. Latch x, y and op into the operand registers and latch the grant into out_src. Go to EXEC.
- Arbitration:
  - Round-robin pointer `last` resets to B, so A wins the first tie.
  - On a tie, the requester that is not `last` wins. `last` updates on every grant.
  - A single requester always wins.
- EXEC: the ALU evaluates the latched operands. out_result is registered, out_valid is set, go to HOLD.
- HOLD:
  - out_valid=1; out_result and out_src are stable.
  - When out_ready=1: clear out_valid, increment op_count, go to IDLE. No new grant is made in the same cycle.
- Ready is never asserted outside IDLE. A requester whose valid is high while the block is busy must hold its command stable and wait.
- ALU semantics: operands are signed N-bit, sign-extended before evaluation, and the result is truncated to N+2 bits.
  - 000: (x+y)/2
  - 001: 2*(x+y)
  - 010: x/2 + y
  - 011: x − y/2
  - 100: (x==0)|(y==0)
  - 101: (x==0)
  - 110: (x==0)&(y==0)
  - 111: x^y
- Division truncates toward zero.
- Logical ops (100, 101, 110) yield 0 or 1, zero-extended.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_result=0, out_src=0, op_count=0, a_ready=b_ready=0.
  - Internal: state=IDLE, `last`=B.
- Latency:
  - Grant in cycle T (ready high in T).
  - out_valid high from cycle T+2.
  - If out_ready is already high at T+2, out_valid drops at T+3 and the next grant can occur at T+3.
- Peak throughput: one command per 3 cycles.
- Back-pressure: out_valid stays high indefinitely while out_ready=0. The result must not change.
- out_ready while out_valid=0 is ignored.
- Simultaneous a_valid and b_valid in IDLE: exactly one ready is asserted, never both.
- op_count wraps from 255 to 0.
- Reset mid-operation:
  - Any latched or in-flight command is discarded.
  - All outputs return to their reset values on the reset edge, without waiting for clk.
  - Requesters must re-present the command.

## Structure
- Package alu_pkg holds:
  - the opcode constants OP_AVG, OP_DBL, OP_HX_Y, OP_X_HY, OP_NOR, OP_NX, OP_NAND, OP_XOR;
  - the state encodings;
  - the source IDs SRC_A and SRC_B.
- Sub-module alu_core is purely combinational: x, y, op → N+2-bit result. It is instantiated once.
- The FSM, arbiter, and operand/result registers live in alu_arbiter_seq.

## Test plan (N=4)
- **Averaging op:** A only, x=3, y=5, op=000 → a_ready pulses once; two cycles later out_result=6'd4, out_src=0; after out_ready, op_count=1.
- **Tie-break rotation:**
  - Step 1: both valid with A(x=3, y=5, op=001) and B(x=−3, y=2, op=010). A wins first → 6'd16. B then wins → 6'd1, confirming −3/2 = −1.
  - Step 2: issue a new simultaneous pair → B-first ordering is not allowed here; A wins, because `last` = B.
- **Back-pressure:** B, x=5, y=−3, op=011 → out_result=6'd6. Hold out_ready=0 for 10 cycles → out_valid, out_result, and out_src stay stable and a_ready/b_ready stay 0 although a_valid=1.
- **Logical ops:**
  - op=110, x=0, y=0 → 1.
  - op=100, x=2, y=7 → 0.
  - op=111, x=3, y=5 → 6.
- **Reset mid-operation:** assert reset during EXEC → outputs are zero immediately; after release, the same pending A command is re-accepted and completes normally.
- **Counter wrap:** 256 consecutive completions → op_count returns to 0.
